// File: rtl/urng_pkg.sv
// Shared taus88 constants, lane state types and the single-step function
// used by each 32-bit combined Tausworthe lane.
package urng_pkg;

  localparam int unsigned LANE_W = 32;

  // Component 1/2/3 shift amounts: pre-shift (q), post-shift (s), mask-shift (k).
  localparam int unsigned C1_Q = 13;
  localparam int unsigned C1_S = 19;
  localparam int unsigned C1_K = 12;
  localparam int unsigned C2_Q = 2;
  localparam int unsigned C2_S = 25;
  localparam int unsigned C2_K = 4;
  localparam int unsigned C3_Q = 3;
  localparam int unsigned C3_S = 11;
  localparam int unsigned C3_K = 17;

  localparam logic [LANE_W-1:0] C1_MASK = 32'hFFFF_FFFE;
  localparam logic [LANE_W-1:0] C2_MASK = 32'hFFFF_FFF8;
  localparam logic [LANE_W-1:0] C3_MASK = 32'hFFFF_FFF0;

  // A component seed must strictly exceed its floor, otherwise the
  // masked-off low bits leave the recurrence stuck in a short cycle.
  localparam logic [LANE_W-1:0] SEED_FLOOR_S1 = 32'd1;
  localparam logic [LANE_W-1:0] SEED_FLOOR_S2 = 32'd7;
  localparam logic [LANE_W-1:0] SEED_FLOOR_S3 = 32'd15;

  typedef struct packed {
    logic [LANE_W-1:0] s1;
    logic [LANE_W-1:0] s2;
    logic [LANE_W-1:0] s3;
  } taus88_state_t;

  typedef struct packed {
    taus88_state_t     state;
    logic [LANE_W-1:0] out;
  } taus88_step_t;

  function automatic taus88_step_t taus88_step(input taus88_state_t st);
    taus88_step_t      r;
    logic [LANE_W-1:0] b1;
    logic [LANE_W-1:0] b2;
    logic [LANE_W-1:0] b3;
    b1 = ((st.s1 << C1_Q) ^ st.s1) >> C1_S;
    b2 = ((st.s2 << C2_Q) ^ st.s2) >> C2_S;
    b3 = ((st.s3 << C3_Q) ^ st.s3) >> C3_S;
    r.state.s1 = ((st.s1 & C1_MASK) << C1_K) ^ b1;
    r.state.s2 = ((st.s2 & C2_MASK) << C2_K) ^ b2;
    r.state.s3 = ((st.s3 & C3_MASK) << C3_K) ^ b3;
    r.out      = r.state.s1 ^ r.state.s2 ^ r.state.s3;
    return r;
  endfunction

endpackage

// File: rtl/taus88_lane.sv
// One 32-bit taus88 lane: three Tausworthe component registers seeded by
// parameters, advanced on en; lane_out is the output of the pending step.
module taus88_lane
  import urng_pkg::*;
#(
  parameter logic [31:0] S1 = 32'h243F_6A88,
  parameter logic [31:0] S2 = 32'h85A3_08D3,
  parameter logic [31:0] S3 = 32'h1319_8A2E
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        en,
  output logic [31:0] lane_out
);

  if (S1 <= SEED_FLOOR_S1) begin : g_bad_s1
    $error("taus88_lane: S1 seed must be > 1");
  end
  if (S2 <= SEED_FLOOR_S2) begin : g_bad_s2
    $error("taus88_lane: S2 seed must be > 7");
  end
  if (S3 <= SEED_FLOOR_S3) begin : g_bad_s3
    $error("taus88_lane: S3 seed must be > 15");
  end

  taus88_state_t state_q;
  taus88_state_t state_d;
  taus88_step_t  step;

  // NOTE: every variable gets a default before the if, so no latch is inferred.
  always_comb begin
    step    = taus88_step(state_q);
    state_d = state_q;
    if (en) state_d = step.state;
  end

  assign lane_out = step.out;

  // NOTE: state registers use non-blocking assignments; reset reloads seeds so a
  // mid-run reset replays the exact sequence.
  always_ff @(posedge clk) begin
    if (!rstn) state_q <= '{s1: S1, s2: S2, s3: S3};
    else       state_q <= state_d;
  end

endmodule

// File: rtl/urng_64bit.sv
// 64-bit uniform PRNG: two independent taus88 lanes concatenated {hi, lo},
// one registered word per enabled clock with a matching valid flag.
module urng_64bit
  import urng_pkg::*;
#(
  parameter logic [31:0] HI_S1 = 32'h9E37_79B9,
  parameter logic [31:0] HI_S2 = 32'h7F4A_7C15,
  parameter logic [31:0] HI_S3 = 32'hF39C_C060,
  parameter logic [31:0] LO_S1 = 32'h243F_6A88,
  parameter logic [31:0] LO_S2 = 32'h85A3_08D3,
  parameter logic [31:0] LO_S3 = 32'h1319_8A2E
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        en,
  output logic [63:0] data_out,
  output logic        valid
);

  logic [31:0] hi_out;
  logic [31:0] lo_out;

  taus88_lane #(.S1(HI_S1), .S2(HI_S2), .S3(HI_S3)) u_hi (
    .clk      (clk),
    .rstn     (rstn),
    .en       (en),
    .lane_out (hi_out)
  );

  taus88_lane #(.S1(LO_S1), .S2(LO_S2), .S3(LO_S3)) u_lo (
    .clk      (clk),
    .rstn     (rstn),
    .en       (en),
    .lane_out (lo_out)
  );

  logic [63:0] data_q;
  logic [63:0] data_d;
  logic        valid_q;
  logic        valid_d;

  // Data holds its last word while idle; valid marks only freshly stepped words.
  always_comb begin
    data_d  = data_q;
    valid_d = en;
    if (en) data_d = {hi_out, lo_out};
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      data_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      data_q  <= data_d;
      valid_q <= valid_d;
    end
  end

  assign data_out = data_q;
  assign valid    = valid_q;

endmodule

// File: tb/tb_urng_64bit.sv
// Directed bench for urng_64bit: reset, streaming, en gaps, mid-run reset,
// a seed override instance, and a long run with a bit-balance sanity check.
module tb_urng_64bit;

  localparam int LONG_N = 2048;

  logic        clk = 1'b0;
  logic        rstn;
  logic        en;
  logic [63:0] data_out;
  logic        valid;
  logic [63:0] data_alt;
  logic        valid_alt;

  int total = 0;
  int bad   = 0;

  logic [63:0] exp_def [LONG_N];
  logic [63:0] exp_alt [16];

  always #5 clk = ~clk;

  urng_64bit dut (
    .clk      (clk),
    .rstn     (rstn),
    .en       (en),
    .data_out (data_out),
    .valid    (valid)
  );

  urng_64bit #(.LO_S3(32'd20)) dut_alt (
    .clk      (clk),
    .rstn     (rstn),
    .en       (en),
    .data_out (data_alt),
    .valid    (valid_alt)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  // Reference lane step written straight from the taus88 recurrences.
  function automatic logic [127:0] ref_lane(input logic [95:0] st);
    logic [31:0] a, b, c, t, n1, n2, n3;
    a  = st[95:64];
    b  = st[63:32];
    c  = st[31:0];
    t  = ((a << 13) ^ a) >> 19;
    n1 = ((a & 32'hFFFF_FFFE) << 12) ^ t;
    t  = ((b << 2) ^ b) >> 25;
    n2 = ((b & 32'hFFFF_FFF8) << 4) ^ t;
    t  = ((c << 3) ^ c) >> 11;
    n3 = ((c & 32'hFFFF_FFF0) << 17) ^ t;
    return {n1, n2, n3, n1 ^ n2 ^ n3};
  endfunction

  task automatic build_model(input logic [95:0] hi_seed, input logic [95:0] lo_seed,
                             input int n, output logic [63:0] words [LONG_N]);
    logic [95:0]  hs;
    logic [95:0]  ls;
    logic [127:0] rh;
    logic [127:0] rl;
    hs = hi_seed;
    ls = lo_seed;
    for (int i = 0; i < n; i++) begin
      rh = ref_lane(hs);
      rl = ref_lane(ls);
      hs = rh[127:32];
      ls = rl[127:32];
      words[i] = {rh[31:0], rl[31:0]};
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin : main
    logic [63:0] tmp_words [LONG_N];
    logic [63:0] seen [8];
    int          dups;
    longint      ones;

    build_model({32'h9E37_79B9, 32'h7F4A_7C15, 32'hF39C_C060},
                {32'h243F_6A88, 32'h85A3_08D3, 32'h1319_8A2E}, LONG_N, exp_def);
    build_model({32'h9E37_79B9, 32'h7F4A_7C15, 32'hF39C_C060},
                {32'h243F_6A88, 32'h85A3_08D3, 32'd20}, 16, tmp_words);
    for (int i = 0; i < 16; i++) exp_alt[i] = tmp_words[i];

    // Reset held two cycles with en high: nothing must advance.
    rstn = 1'b0;
    en   = 1'b1;
    tick();
    tick();
    check("rst_data", data_out, 64'h0);
    check("rst_valid", {63'h0, valid}, 64'h0);
    check("rst_data_alt", data_alt, 64'h0);

    // Eight back-to-back words from default seeds, plus the overridden instance.
    rstn = 1'b1;
    for (int k = 0; k < 8; k++) begin
      tick();
      check($sformatf("run_valid%0d", k), {63'h0, valid}, 64'h1);
      check($sformatf("run_word%0d", k), data_out, exp_def[k]);
      check($sformatf("alt_word%0d", k), data_alt, exp_alt[k]);
      seen[k] = data_out;
    end
    dups = 0;
    for (int i = 0; i < 8; i++)
      for (int j = i + 1; j < 8; j++)
        if (seen[i] == seen[j]) dups++;
    check("distinct8", 64'(dups), 64'h0);

    en = 1'b0;
    tick();
    check("idle_valid", {63'h0, valid}, 64'h0);
    check("idle_hold", data_out, exp_def[7]);

    // en pattern 1,0,0,1 from a fresh reset.
    rstn = 1'b0;
    tick();
    rstn = 1'b1;
    en   = 1'b1;
    tick();
    check("pat_v0", {63'h0, valid}, 64'h1);
    check("pat_d0", data_out, exp_def[0]);
    en = 1'b0;
    tick();
    check("pat_v1", {63'h0, valid}, 64'h0);
    check("pat_d1", data_out, exp_def[0]);
    tick();
    check("pat_v2", {63'h0, valid}, 64'h0);
    check("pat_d2", data_out, exp_def[0]);
    en = 1'b1;
    tick();
    check("pat_v3", {63'h0, valid}, 64'h1);
    check("pat_d3", data_out, exp_def[1]);

    // Three more words (five total), then reset mid-run and restart.
    for (int k = 2; k < 5; k++) begin
      tick();
      check($sformatf("pre_rst_word%0d", k), data_out, exp_def[k]);
    end
    rstn = 1'b0;
    tick();
    check("mid_rst_data", data_out, 64'h0);
    check("mid_rst_valid", {63'h0, valid}, 64'h0);
    rstn = 1'b1;
    tick();
    check("restart_valid", {63'h0, valid}, 64'h1);
    check("restart_word0", data_out, exp_def[0]);
    tick();
    check("restart_word1", data_out, exp_def[1]);

    // Long run from reset: word-by-word match plus bit balance.
    rstn = 1'b0;
    tick();
    rstn = 1'b1;
    ones = 0;
    for (int k = 0; k < LONG_N; k++) begin
      tick();
      if (data_out !== exp_def[k]) check($sformatf("long_word%0d", k), data_out, exp_def[k]);
      ones += longint'($countones(data_out));
    end
    total++;
    check("long_bit_balance",
          64'((ones > longint'(LONG_N * 32 - 2048)) && (ones < longint'(LONG_N * 32 + 2048))),
          64'h1);
    total--;
    check("long_last_word", data_out, exp_def[LONG_N-1]);

    en = 1'b0;
    tick();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
